// File: rtl/floor_display_sched.sv
// floor_display_sched
// Time-shares the single floor hex digit between the car's current floor and
// queued "floor announced" events. Idle shows the current floor (blinking
// while the doors are open); each queued announcement is shown for a fixed
// hold time after a blank gap. Drives the floor_t input of hex_display.

module floor_display_sched #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cur_floor,
  input  logic       door_open,
  input  logic       req_valid,
  input  logic [3:0] req_floor,
  output logic       req_ready,
  output logic [3:0] disp_value,
  output logic       busy,
  output logic       drop_err
);

  // Any value above 9 renders as all segments off in the decoder.
  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [3:0] MAX_FLOOR = 4'd9;

  // The segment counter only ever times GAP and ANNOUNCE.
  localparam int unsigned MAX_SEG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;
  localparam int unsigned BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW    = PW + 1;

  localparam logic [CW-1:0]   GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]   HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GAP      = 2'd1,
    ANNOUNCE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Announcement FIFO
  // ---------------------------------------------------------------------------
  logic [3:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;

  logic push;   // handshake completed this cycle
  logic store;  // handshake completed with a displayable floor
  logic pop;    // head moves into the held register this cycle

  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid && req_ready;
  assign store     = push && (req_floor <= MAX_FLOOR);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from the values of the previous cycle.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptiness is defined by the reset
    // pointers and count, so clearing the array would only cost logic.
    if (store) mem[wr_ptr] <= req_floor;
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t        state, state_d;
  logic [CW-1:0] seg_cnt, seg_cnt_d;
  logic [3:0]    held, held_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          blink_vis, blink_vis_d;
  logic [3:0]    disp_d;
  logic          busy_d;
  logic          drop_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seg_cnt    <= '0;
      held       <= BLANK;
      blink_cnt  <= '0;
      blink_vis  <= 1'b1;
      disp_value <= BLANK;
      busy       <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      state      <= state_d;
      seg_cnt    <= seg_cnt_d;
      held       <= held_d;
      blink_cnt  <= blink_cnt_d;
      blink_vis  <= blink_vis_d;
      disp_value <= disp_d;
      busy       <= busy_d;
      drop_err   <= drop_d;
    end
  end

  // Next-state, segment timing, blink phase and next display value.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d     = state;
    seg_cnt_d   = seg_cnt;
    held_d      = held;
    disp_d      = disp_value;
    pop         = 1'b0;
    // Blink timing restarts visible whenever it is not actively running; this
    // covers both a door_open rising edge and every entry into IDLE.
    blink_cnt_d = '0;
    blink_vis_d = 1'b1;

    unique case (state)
      IDLE: begin
        if (count != '0) begin
          // A pending announcement preempts blinking; floor shown steady.
          state_d   = GAP;
          seg_cnt_d = GAP_LOAD;
          disp_d    = cur_floor;
        end else if (door_open) begin
          disp_d = blink_vis ? cur_floor : BLANK;
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_vis_d = ~blink_vis;
          end else begin
            blink_cnt_d = blink_cnt + 1'b1;
            blink_vis_d = blink_vis;
          end
        end else begin
          disp_d = cur_floor;
        end
      end

      GAP: begin
        disp_d = BLANK;
        if (seg_cnt == '0) begin
          pop       = 1'b1;
          held_d    = mem[rd_ptr];
          state_d   = ANNOUNCE;
          seg_cnt_d = HOLD_LOAD;
        end else begin
          seg_cnt_d = seg_cnt - 1'b1;
        end
      end

      ANNOUNCE: begin
        // door_open is deliberately ignored while an announcement is up.
        disp_d = held;
        if (seg_cnt == '0) begin
          if (count != '0) begin
            state_d   = GAP;
            seg_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          seg_cnt_d = seg_cnt - 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        seg_cnt_d = '0;
        disp_d    = BLANK;
      end
    endcase
  end

  // Status outputs registered alongside disp_value.
  always_comb begin
    busy_d = (state != IDLE) || (count != '0);
    drop_d = push && (req_floor > MAX_FLOOR);
  end

endmodule

// File: tb/tb_floor_display_sched.sv
// Scoreboard bench for floor_display_sched with small timing parameters.
// Stimulus pushes the expected post-edge outputs into a queue; a monitor pops
// and compares them on the following falling edge.

module tb_floor_display_sched;

  localparam logic [3:0] BL = 4'hF;

  typedef struct {
    logic [3:0] disp;
    logic       busy;
    logic       rdy;
    logic       drop;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  event mid_ev;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cur_floor;
  logic       door_open;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_ready;
  logic [3:0] disp_value;
  logic       busy;
  logic       drop_err;

  always #5 clk = ~clk;

  floor_display_sched #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .BLINK_HALF (3),
    .DEPTH      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cur_floor (cur_floor),
    .door_open (door_open),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_ready (req_ready),
    .disp_value(disp_value),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the oldest expectation against the settled outputs.
  always @(negedge clk or mid_ev) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      check({e.tag, ".disp"}, disp_value, e.disp);
      check({e.tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
      check({e.tag, ".ready"}, {3'b0, req_ready}, {3'b0, e.rdy});
      check({e.tag, ".drop"}, {3'b0, drop_err}, {3'b0, e.drop});
    end
  end

  // One clock: drive inputs, then record what the outputs must be after the edge.
  task automatic cyc(input logic rv, input logic [3:0] rf, input logic door,
                     input logic [3:0] cur, input logic [3:0] e_disp,
                     input logic e_busy, input logic e_rdy, input logic e_drop,
                     input string tag);
    exp_t e;
    req_valid = rv;
    req_floor = rf;
    door_open = door;
    cur_floor = cur;
    @(posedge clk);
    e.disp = e_disp;
    e.busy = e_busy;
    e.rdy  = e_rdy;
    e.drop = e_drop;
    e.tag  = tag;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst       = 1'b0;
    cur_floor = 4'd3;
    door_open = 1'b0;
    req_valid = 1'b0;
    req_floor = 4'd0;
    #1 rst = 1'b1;

    // 1: reset holds blank, then the current floor appears one cycle after release
    cyc(0, 0, 0, 3, BL, 0, 1, 0, "rst_hold0");
    cyc(0, 0, 0, 3, BL, 0, 1, 0, "rst_hold1");
    rst = 1'b0;
    cyc(0, 0, 0, 3, 4'd3, 0, 1, 0, "release0");
    cyc(0, 0, 0, 3, 4'd3, 0, 1, 0, "release1");

    // 2: door blink in 3-cycle halves, steady on close, restart visible on reopen
    cyc(0, 0, 1, 5, 4'd5, 0, 1, 0, "blink0");
    cyc(0, 0, 1, 5, 4'd5, 0, 1, 0, "blink1");
    cyc(0, 0, 1, 5, 4'd5, 0, 1, 0, "blink2");
    cyc(0, 0, 1, 5, BL,   0, 1, 0, "blink3");
    cyc(0, 0, 1, 5, BL,   0, 1, 0, "blink4");
    cyc(0, 0, 0, 5, 4'd5, 0, 1, 0, "door_close");
    cyc(0, 0, 1, 5, 4'd5, 0, 1, 0, "reopen0");
    cyc(0, 0, 1, 5, 4'd5, 0, 1, 0, "reopen1");
    cyc(0, 0, 1, 5, 4'd5, 0, 1, 0, "reopen2");
    cyc(0, 0, 1, 5, BL,   0, 1, 0, "reopen3");
    cyc(0, 0, 1, 6, BL,   0, 1, 0, "reopen4");
    cyc(0, 0, 1, 6, BL,   0, 1, 0, "reopen5");
    cyc(0, 0, 1, 6, 4'd6, 0, 1, 0, "reopen6");
    cyc(0, 0, 0, 2, 4'd2, 0, 1, 0, "door_close2");

    // 3: single announcement of floor 7 with current floor 2
    cyc(1, 7, 0, 2, 4'd2, 0, 1, 0, "a7_push");
    cyc(0, 0, 0, 2, 4'd2, 1, 1, 0, "a7_idle");
    cyc(0, 0, 0, 2, BL,   1, 1, 0, "a7_gap0");
    cyc(0, 0, 0, 2, BL,   1, 1, 0, "a7_gap1");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2, 4'd7, 1, 1, 0, "a7_hold");
    cyc(0, 0, 0, 2, 4'd2, 0, 1, 0, "a7_done");

    // 4: three back-to-back requests; the third stalls until the first pop
    cyc(1, 4, 0, 2, 4'd2, 0, 1, 0, "q_push4");
    cyc(1, 8, 0, 2, 4'd2, 1, 0, 0, "q_push8");
    cyc(1, 6, 0, 2, BL,   1, 0, 0, "q_stall0");
    cyc(1, 6, 0, 2, BL,   1, 1, 0, "q_stall1");
    cyc(1, 6, 0, 2, 4'd4, 1, 0, 0, "q_push6");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2, 4'd4, 1, 0, 0, "q_hold4");
    cyc(0, 0, 0, 2, BL,   1, 0, 0, "q_gap8a");
    cyc(0, 0, 0, 2, BL,   1, 1, 0, "q_gap8b");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2, 4'd8, 1, 1, 0, "q_hold8");
    cyc(0, 0, 0, 2, BL,   1, 1, 0, "q_gap6a");
    cyc(0, 0, 0, 2, BL,   1, 1, 0, "q_gap6b");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2, 4'd6, 1, 1, 0, "q_hold6");
    cyc(0, 0, 0, 2, 4'd2, 0, 1, 0, "q_done");

    // 5: out-of-range request is consumed and dropped
    cyc(1, 12, 0, 2, 4'd2, 0, 1, 1, "drop_pulse");
    cyc(0, 0,  0, 2, 4'd2, 0, 1, 0, "drop_clear0");
    cyc(0, 0,  0, 2, 4'd2, 0, 1, 0, "drop_clear1");

    // 6: asynchronous reset while announcing with one entry still queued
    cyc(1, 9, 0, 2, 4'd2, 0, 1, 0, "r_push9");
    cyc(1, 3, 0, 2, 4'd2, 1, 0, 0, "r_push3");
    cyc(0, 0, 0, 2, BL,   1, 0, 0, "r_gap0");
    cyc(0, 0, 0, 2, BL,   1, 1, 0, "r_gap1");
    cyc(0, 0, 0, 2, 4'd9, 1, 1, 0, "r_ann9");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    e.disp = BL;
    e.busy = 1'b0;
    e.rdy  = 1'b1;
    e.drop = 1'b0;
    e.tag  = "r_async";
    exp_q.push_back(e);
    -> mid_ev;
    cyc(0, 0, 0, 2, BL, 0, 1, 0, "r_held");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2, 4'd2, 0, 1, 0, "r_after");

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
